// File: rtl/regfile_pkg.sv
// regfile_pkg: copy-FSM states and condition-flag layout shared by the banked register file.
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, COPY, DONE} copy_state_t;
  localparam int COND_W = 3;
  localparam int ZERO = 2;
  localparam int POS = 1;
  localparam int NEG = 0;
endpackage

// File: rtl/banked_regfile_if.sv
// banked_regfile_if: read/write/bank-select/copy signals of the banked register file.
interface banked_regfile_if #(
  parameter int DATA_W = 16,
  parameter int REG_CNT = 8,
  parameter int BANK_CNT = 2
);
  import regfile_pkg::*;
  localparam int IW = $clog2(REG_CNT);
  localparam int BW = $clog2(BANK_CNT);
  logic [IW-1:0] rd_a_num, rd_b_num, wr_num;
  logic [DATA_W-1:0] rd_a_data, rd_b_data, pc_out, wr_data;
  logic [COND_W-1:0] cond_out;
  logic wr_en, copy_req, copy_busy, copy_done;
  logic [BW-1:0] bank_sel, copy_src, copy_dst;
  modport master (
    output rd_a_num, rd_b_num, wr_num, wr_data, wr_en, bank_sel, copy_req, copy_src, copy_dst,
    input rd_a_data, rd_b_data, pc_out, cond_out, copy_busy, copy_done
  );
  modport slave (
    input rd_a_num, rd_b_num, wr_num, wr_data, wr_en, bank_sel, copy_req, copy_src, copy_dst,
    output rd_a_data, rd_b_data, pc_out, cond_out, copy_busy, copy_done
  );
endinterface

// File: rtl/regfile_copy_fsm.sv
// regfile_copy_fsm: sequences a bank-to-bank copy of registers 1..REG_CNT-1, one per cycle.
module regfile_copy_fsm
  import regfile_pkg::*;
#(
  parameter int REG_CNT = 8,
  parameter int BANK_CNT = 2,
  localparam int IW = $clog2(REG_CNT),
  localparam int BW = $clog2(BANK_CNT)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic [BW-1:0] src_in,
  input  logic [BW-1:0] dst_in,
  output logic busy,
  output logic done,
  output logic last,
  output logic [IW-1:0] idx,
  output logic [BW-1:0] src,
  output logic [BW-1:0] dst
);
  localparam logic [IW-1:0] LAST_IDX = IW'(REG_CNT - 1);
  copy_state_t state, next;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      src <= '0;
      dst <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        src <= src_in;
        dst <= dst_in;
        idx <= IW'(1);
      end else if (state == COPY) idx <= idx + 1'b1;
    end
  end
  always_comb
    next = state == IDLE ? (req ? (src_in != dst_in ? COPY : DONE) : IDLE)
         : state == COPY ? (last ? DONE : COPY)
         : IDLE;
  always_comb begin
    busy = state == COPY;
    last = busy && idx == LAST_IDX;
    done = state == DONE;
  end
endmodule

// File: rtl/banked_regfile.sv
// banked_regfile: multi-bank register file with per-bank flags and bank copy engine.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports and pc_out.
module banked_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_CNT = 8,
  parameter int BANK_CNT = 2,
  parameter int PC_REG = 6
) (
  input logic clk,
  input logic rst,
  banked_regfile_if.slave bus
);
  localparam int IW = $clog2(REG_CNT);
  localparam int BW = $clog2(BANK_CNT);
  localparam logic [IW-1:0] PC_IDX = IW'(PC_REG);
  logic [DATA_W-1:0] regs [BANK_CNT][REG_CNT];
  logic [COND_W-1:0] flags [BANK_CNT];
  logic [COND_W-1:0] new_flags;
  logic cp_busy, cp_last;
  logic [IW-1:0] cp_idx;
  logic [BW-1:0] cp_src, cp_dst;
  regfile_copy_fsm #(.REG_CNT(REG_CNT), .BANK_CNT(BANK_CNT)) u_fsm (
    .clk(clk), .rst(rst), .req(bus.copy_req), .src_in(bus.copy_src), .dst_in(bus.copy_dst),
    .busy(cp_busy), .done(bus.copy_done), .last(cp_last), .idx(cp_idx), .src(cp_src), .dst(cp_dst)
  );
  always_comb begin
    new_flags = '0;
    new_flags[ZERO] = bus.wr_data == '0;
    new_flags[POS] = bus.wr_data != '0 && !bus.wr_data[DATA_W-1];
    new_flags[NEG] = bus.wr_data[DATA_W-1];
  end
  // User write is issued after the copy write so it wins on any collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANK_CNT; b++) begin
        flags[b] <= '0;
        for (int r = 0; r < REG_CNT; r++) regs[b][r] <= '0;
      end
    end else begin
      if (cp_busy) regs[cp_dst][cp_idx] <= regs[cp_src][cp_idx];
      if (cp_last) flags[cp_dst] <= flags[cp_src];
      if (bus.wr_en && bus.wr_num != '0) regs[bus.bank_sel][bus.wr_num] <= bus.wr_data;
      if (bus.wr_en) flags[bus.bank_sel] <= new_flags;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = bus.wr_en && bus.wr_num != '0;
  assign bus.rd_a_data = wr_live && bus.wr_num == bus.rd_a_num ? bus.wr_data : regs[bus.bank_sel][bus.rd_a_num];
  assign bus.rd_b_data = wr_live && bus.wr_num == bus.rd_b_num ? bus.wr_data : regs[bus.bank_sel][bus.rd_b_num];
  assign bus.pc_out = wr_live && bus.wr_num == PC_IDX ? bus.wr_data : regs[bus.bank_sel][PC_IDX];
`else
  assign bus.rd_a_data = regs[bus.bank_sel][bus.rd_a_num];
  assign bus.rd_b_data = regs[bus.bank_sel][bus.rd_b_num];
  assign bus.pc_out = regs[bus.bank_sel][PC_IDX];
`endif
  assign bus.cond_out = flags[bus.bank_sel];
  assign bus.copy_busy = cp_busy;
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed checks of banked_regfile reads, flags, banking, copy, reset and bypass.
module tb_banked_regfile;
  logic clk = 0;
  logic rst;
  int total = 0, passed = 0;
  int busy_cnt, done_cnt;
  banked_regfile_if #(.DATA_W(16), .REG_CNT(8), .BANK_CNT(2)) bus ();
  banked_regfile #(.DATA_W(16), .REG_CNT(8), .BANK_CNT(2), .PC_REG(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [2:0] num, input logic [15:0] data);
    bus.wr_en = 1; bus.wr_num = num; bus.wr_data = data;
    tick();
    bus.wr_en = 0;
  endtask
  initial begin
    rst = 1;
    bus.rd_a_num = 0; bus.rd_b_num = 0; bus.wr_num = 0; bus.wr_data = 0; bus.wr_en = 0;
    bus.bank_sel = 0; bus.copy_req = 0; bus.copy_src = 0; bus.copy_dst = 0;
    tick(); tick();
    rst = 0;
    bus.rd_a_num = 3;
    #1;
    check("rst_r3", bus.rd_a_data, 0);
    check("rst_cond", bus.cond_out, 0);
    check("rst_busy", bus.copy_busy, 0);
    check("rst_done", bus.copy_done, 0);
    write(3, 16'h1234);
    #1;
    check("r3_data", bus.rd_a_data, 16'h1234);
    check("r3_cond", bus.cond_out, 3'b010);
    write(0, 16'hFFFF);
    bus.rd_a_num = 0;
    #1;
    check("r0_zero", bus.rd_a_data, 0);
    check("r0_cond", bus.cond_out, 3'b001);
    write(2, 16'hAAAA);
    bus.rd_a_num = 2; bus.bank_sel = 1;
    #1;
    check("b1_r2", bus.rd_a_data, 0);
    check("b1_cond", bus.cond_out, 0);
    bus.bank_sel = 0;
    #1;
    check("b0_r2", bus.rd_a_data, 16'hAAAA);
    check("b0_cond", bus.cond_out, 3'b001);
    write(1, 16'h0000);
    check("zero_cond", bus.cond_out, 3'b100);
    bus.rd_b_num = 6; bus.wr_en = 1; bus.wr_num = 6; bus.wr_data = 16'h0042;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd_b", bus.rd_b_data, 16'h0042);
    check("byp_pc", bus.pc_out, 16'h0042);
`else
    check("nobyp_rd_b", bus.rd_b_data, 0);
    check("nobyp_pc", bus.pc_out, 0);
`endif
    check("byp_cond", bus.cond_out, 3'b100);
    tick();
    bus.wr_en = 0;
    check("pc_after", bus.pc_out, 16'h0042);
    for (int i = 1; i < 8; i++) write(3'(i), 16'(16'h0101 * i));
    bus.copy_req = 1; bus.copy_src = 0; bus.copy_dst = 1;
    tick();
    bus.copy_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) begin
        bus.bank_sel = 1; bus.wr_en = 1; bus.wr_num = 4; bus.wr_data = 16'hBEEF;
      end
      #1;
      busy_cnt += int'(bus.copy_busy);
      done_cnt += int'(bus.copy_done);
      if (bus.copy_done) check("done_busy", bus.copy_busy, 0);
      tick();
      bus.wr_en = 0; bus.bank_sel = 0;
    end
    check("copy_busy_cycles", busy_cnt, 7);
    check("copy_done_pulses", done_cnt, 1);
    bus.bank_sel = 1;
    for (int r = 1; r < 8; r++) begin
      bus.rd_a_num = 3'(r);
      #1;
      check($sformatf("b1_r%0d", r), bus.rd_a_data, r == 4 ? 16'hBEEF : 16'(16'h0101 * r));
    end
    check("b1_flags", bus.cond_out, 3'b010);
    bus.bank_sel = 0; bus.rd_a_num = 5;
    bus.copy_req = 1; bus.copy_src = 1; bus.copy_dst = 1;
    tick();
    bus.copy_req = 0;
    check("same_done", bus.copy_done, 1);
    check("same_busy", bus.copy_busy, 0);
    tick();
    check("same_done_end", bus.copy_done, 0);
    check("same_untouched", bus.rd_a_data, 16'h0505);
    bus.copy_req = 1; bus.copy_src = 1; bus.copy_dst = 0;
    tick();
    bus.copy_req = 0;
    tick(); tick();
    check("abort_busy_pre", bus.copy_busy, 1);
    rst = 1;
    tick();
    rst = 0;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      done_cnt += int'(bus.copy_done);
      busy_cnt += int'(bus.copy_busy);
      tick();
    end
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy_cnt, 0);
    for (int b = 0; b < 2; b++) begin
      bus.bank_sel = 1'(b);
      for (int r = 0; r < 8; r++) begin
        bus.rd_a_num = 3'(r);
        #1;
        check($sformatf("abort_b%0d_r%0d", b, r), bus.rd_a_data, 0);
      end
      check($sformatf("abort_b%0d_cond", b), bus.cond_out, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter REG_CNT, default 8, registers per bank; power of two, >= 4.
REQ-003 Parameter BANK_CNT, default 2, number of banks; power of two, >= 2.
REQ-004 Parameter PC_REG, default 6, index of the register driven on pc_out.
REQ-005 One clock, clk; reset is synchronous and active-high, rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rd_a_num / rd_b_num  in  log2(REG_CNT)  read-port register indices.
REQ-009 rd_a_data / rd_b_data  out  DATA_W  read-port data from the active bank.
REQ-010 pc_out  out  DATA_W  register PC_REG of the active bank.
REQ-011 cond_out  out  3  {zero, positive, negative} flags of the active bank.
REQ-012 wr_num  in  log2(REG_CNT), wr_data  in  DATA_W, wr_en  in  1: write port into the active bank.
REQ-013 bank_sel  in  log2(BANK_CNT)  active bank select.
REQ-014 copy_req  in  1, copy_src / copy_dst  in  log2(BANK_CNT): bank-copy request.
REQ-015 copy_busy  out  1  copy in progress; copy_done  out  1  one-cycle completion pulse.

Function
REQ-016 Register 0 of every bank SHALL read as 0; writes to it SHALL be discarded.
REQ-017 Reads SHALL be combinational from the active bank; a write SHALL become visible on the cycle after the clock edge that performs it.
REQ-018 On wr_en with wr_num != 0, wr_data SHALL be stored in bank bank_sel, register wr_num, at the clock edge.
REQ-019 On any wr_en, including wr_num == 0, the active bank's flags SHALL update to zero = (wr_data == 0), positive = (wr_data != 0 and wr_data[DATA_W-1] == 0), negative = wr_data[DATA_W-1].
REQ-020 Each bank SHALL hold its own flags; changing bank_sel SHALL switch cond_out, pc_out and both read ports in the same cycle.
REQ-021 The copy FSM SHALL have states IDLE, COPY and DONE.
REQ-022 In IDLE, copy_req with copy_src != copy_dst SHALL latch src/dst and enter COPY, with copy_busy high from the next cycle.
REQ-023 COPY SHALL write one register per cycle, indices 1..REG_CNT-1 ascending, src into dst, for REG_CNT-1 cycles.
REQ-024 The last COPY cycle SHALL also copy the src flags into the dst flags.
REQ-025 COPY SHALL then enter DONE, which asserts copy_done for exactly one cycle (copy_busy low) and returns to IDLE.
REQ-026 In IDLE, copy_req with copy_src == copy_dst SHALL go straight to DONE without writing anything.
REQ-027 copy_req outside IDLE SHALL be ignored.
REQ-028 The user write port SHALL stay functional during COPY.
REQ-029 If a user write and a copy write target the same bank and register in the same cycle, the user write SHALL win.
REQ-030 If a user write and the final flag copy target the same bank in the same cycle, the user flag update SHALL win.

Reset
REQ-031 While rst is high at a clock edge: all registers in all banks SHALL clear to 0, all flags SHALL clear to 0, the FSM SHALL go to IDLE, and copy_busy = copy_done = 0.
REQ-032 Reset during COPY SHALL abort the copy with no copy_done pulse; reset takes priority over wr_en and copy_req.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined, a read of the register being written this cycle (active bank, wr_en, wr_num != 0) SHALL return wr_data combinationally on rd_a_data, rd_b_data and pc_out.
REQ-034 Without REGFILE_BYPASS_EN, those outputs SHALL return the stored value until the next cycle.
REQ-035 cond_out SHALL never be bypassed.

Structure
REQ-036 Package regfile_pkg SHALL hold the copy-state enum, the flag bit-index constants (ZERO=2, POS=1, NEG=0) and COND_W=3.
REQ-037 The copy FSM and its index counter SHALL be the sub-module regfile_copy_fsm; storage and muxing stay in banked_regfile.

Verification
REQ-038 Reset, write r3=0x1234 in bank 0 -> next cycle rd_a_num=3 reads 0x1234 and cond_out=3'b010; writing r0=0xFFFF -> r0 reads 0 and cond_out=3'b001.
REQ-039 Write r2=0xAAAA in bank 0, set bank_sel=1 -> r2 reads 0 and cond_out=0; set bank_sel=0 -> r2 reads 0xAAAA.
REQ-040 Fill bank 0 r1..r7 with 0x0101..0x0707, then pulse copy_req src=0 dst=1 -> copy_busy high for 7 cycles, copy_done pulses once, and bank 1 matches bank 0 including flags.
REQ-041 During that copy, a user write r4=0xBEEF to bank 1 on r4's copy cycle -> bank 1 r4 = 0xBEEF after done.
REQ-042 Assert rst on the 3rd COPY cycle -> no copy_done pulse, all registers read 0, copy_busy low.
REQ-043 With REGFILE_BYPASS_EN, write r6=0x0042 with rd_b_num=6 -> rd_b_data and pc_out show 0x0042 in the same cycle; without the macro, the old value that cycle.
